// File: rtl/hex_sr_pkg.sv
// hex_sr_pkg
//   Shared definitions for the six-lane recirculating hex shift register
//   driver: lane count, the word type carried on every data path, and the
//   driver state encoding.
package hex_sr_pkg;

    localparam int SR_LANES = 6;

    typedef logic [SR_LANES-1:0] hex_word_t;

    // Each SR shift is a SETUP/SHIFT pair: SETUP holds sr_clk low, SHIFT holds it high.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_SETUP = 3'd1,
        LD_SHIFT = 3'd2,
        RD_SETUP = 3'd3,
        RD_SHIFT = 3'd4
    } hex_sr_drv_state_t;

endpackage

// File: rtl/hex_sr_driver.sv
// hex_sr_driver
//   Host-side initiator for the six-lane recirculating hex shift register.
//   A load pass shifts LENGTH words from the write stream into the SR with
//   recirculation off. A read pass clocks the SR LENGTH times with
//   recirculation on and hands each tail word to the read stream, so the SR
//   holds the same contents afterwards.
//
//   Optional feature macro: HEX_SR_DRV_CHECK_EN
//     defined   -> XOR checksum of the loaded words is compared with the XOR of
//                  the words read back; a difference raises chk_err.
//     undefined -> no checksum logic, chk_err is tied low.
//
// Ports
//   clk        system clock, all state on its rising edge
//   rst_n      asynchronous active-low reset
//   cmd_load   pulse, starts a load pass (honoured in IDLE only)
//   cmd_read   pulse, starts a read pass (honoured in IDLE only; load wins)
//   wr_data    word to shift in          wr_valid / wr_ready  write handshake
//   rd_data    word read from SR tail    rd_valid / rd_ready  read handshake
//   busy       high while a pass is running
//   sr_clk     SR shift clock, registered, clk/2 while shifting
//   sr_recirc  SR recirculate select, registered
//   sr_d       SR data lanes, registered
//   sr_q       SR tail-word lanes
//   chk_err    readback checksum mismatch
module hex_sr_driver
    import hex_sr_pkg::*;
#(
    parameter int LENGTH = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_load,
    input  logic                cmd_read,
    input  logic [SR_LANES-1:0] wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [SR_LANES-1:0] rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                busy,
    output logic                sr_clk,
    output logic                sr_recirc,
    output logic [SR_LANES-1:0] sr_d,
    input  logic [SR_LANES-1:0] sr_q,
    output logic                chk_err
);

    localparam int              CNT_W    = $clog2(LENGTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

    hex_sr_drv_state_t state;
    logic [CNT_W-1:0]  cnt;
    logic              rd_take;

    // A read word may be captured when the output slot is empty or is being
    // emptied by the consumer in this same cycle.
    assign rd_take  = (state == RD_SETUP) && (!rd_valid || rd_ready);
    assign wr_ready = (state == LD_SETUP);
    assign busy     = (state != IDLE);

`ifdef HEX_SR_DRV_CHECK_EN
    hex_word_t ld_sum;   // running XOR of words accepted in the current load
    hex_word_t ref_sum;  // checksum of the last completed load
    hex_word_t rd_sum;   // running XOR of words captured in the current read
`else
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Reset drops sr_clk at once, so an aborted pass never produces a
            // further SR shift.
            state     <= IDLE;
            cnt       <= '0;
            sr_clk    <= 1'b0;
            sr_recirc <= 1'b1;
            sr_d      <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
`ifdef HEX_SR_DRV_CHECK_EN
            ld_sum    <= '0;
            ref_sum   <= '0;
            rd_sum    <= '0;
            chk_err   <= 1'b0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // branch below sees the pre-edge values, independent of order.
            // Consumer drained the slot; a capture later in this cycle overrides.
            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    sr_clk    <= 1'b0;
                    sr_recirc <= 1'b1;
                    // A pending read word blocks any new pass.
                    if (!rd_valid) begin
                        if (cmd_load) begin
                            state     <= LD_SETUP;
                            cnt       <= '0;
                            sr_recirc <= 1'b0;
`ifdef HEX_SR_DRV_CHECK_EN
                            ld_sum    <= '0;
`endif
                        end else if (cmd_read) begin
                            state   <= RD_SETUP;
                            cnt     <= '0;
`ifdef HEX_SR_DRV_CHECK_EN
                            rd_sum  <= '0;
                            chk_err <= 1'b0;
`endif
                        end
                    end
                end

                LD_SETUP: begin
                    if (wr_valid) begin
                        sr_d   <= wr_data;
                        sr_clk <= 1'b1;
                        state  <= LD_SHIFT;
`ifdef HEX_SR_DRV_CHECK_EN
                        ld_sum <= ld_sum ^ wr_data;
`endif
                    end
                end

                LD_SHIFT: begin
                    sr_clk <= 1'b0;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        sr_recirc <= 1'b1;
`ifdef HEX_SR_DRV_CHECK_EN
                        ref_sum   <= ld_sum;
`endif
                    end else begin
                        state <= LD_SETUP;
                    end
                end

                RD_SETUP: begin
                    // sr_q is taken on the edge that raises sr_clk, i.e. the
                    // tail word before the SR moves.
                    if (rd_take) begin
                        rd_data  <= sr_q;
                        rd_valid <= 1'b1;
                        sr_clk   <= 1'b1;
                        state    <= RD_SHIFT;
`ifdef HEX_SR_DRV_CHECK_EN
                        rd_sum   <= rd_sum ^ sr_q;
`endif
                    end
                end

                RD_SHIFT: begin
                    sr_clk <= 1'b0;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state   <= IDLE;
`ifdef HEX_SR_DRV_CHECK_EN
                        chk_err <= (rd_sum != ref_sum);
`endif
                    end else begin
                        state <= RD_SETUP;
                    end
                end

                // NOTE: an explicit default keeps illegal encodings recoverable
                // and leaves no path without an assignment to state.
                default: begin
                    state  <= IDLE;
                    sr_clk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_sr_driver.sv
// tb_hex_sr_driver
//   Bench for hex_sr_driver with LENGTH=4. A behavioural recirculating SR
//   (a queue whose front is the tail word) sits on the sr_* pins; expected
//   read words are the SR contents at the start of each read pass.
module tb_hex_sr_driver;
    import hex_sr_pkg::*;

    localparam int LENGTH = 4;
`ifdef HEX_SR_DRV_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic      clk      = 1'b0;
    logic      rst_n    = 1'b0;
    logic      cmd_load = 1'b0;
    logic      cmd_read = 1'b0;
    hex_word_t wr_data  = '0;
    logic      wr_valid = 1'b0;
    logic      wr_ready;
    hex_word_t rd_data;
    logic      rd_valid;
    logic      rd_ready = 1'b0;
    logic      busy;
    logic      sr_clk;
    logic      sr_recirc;
    hex_word_t sr_d;
    hex_word_t sr_q     = '0;
    logic      chk_err;

    hex_word_t sr_model[$] = '{6'h00, 6'h00, 6'h00, 6'h00};
    int        shift_cnt       = 0;
    int        plain_shift_cnt = 0;
    int        busy_cycles     = 0;
    logic      corrupt_pulse   = 1'b0;
    hex_word_t last_load_sum   = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hex_sr_driver #(.LENGTH(LENGTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_load  (cmd_load),
        .cmd_read  (cmd_read),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .sr_clk    (sr_clk),
        .sr_recirc (sr_recirc),
        .sr_d      (sr_d),
        .sr_q      (sr_q),
        .chk_err   (chk_err)
    );

    // Behavioural SR: each sr_clk rise drops the tail word and appends either
    // the tail word (recirculate) or sr_d. corrupt_pulse overwrites word 2.
    always @(posedge sr_clk or posedge corrupt_pulse) begin
        hex_word_t w;
        if (corrupt_pulse) begin
            sr_model[2] = 6'h01;
        end else begin
            w = sr_recirc ? sr_model[0] : sr_d;
            void'(sr_model.pop_front());
            sr_model.push_back(w);
            shift_cnt++;
            if (!sr_recirc) plain_shift_cnt++;
        end
        sr_q = sr_model[0];
    end

    always @(negedge clk) if (busy) busy_cycles++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic hex_word_t xor_of(input hex_word_t q[$]);
        hex_word_t s = '0;
        foreach (q[i]) s ^= q[i];
        return s;
    endfunction

    // gap < 0 picks a random 0..3 cycle gap before each word.
    task automatic run_load(input hex_word_t w[$], input int gap, input bit with_read,
                            input bit poke_read, input bit complete);
        int sb, pb, bb, g, k, viol;
        sb = shift_cnt; pb = plain_shift_cnt; bb = busy_cycles; viol = 0;
        cmd_load = 1'b1; cmd_read = with_read;
        @(negedge clk);
        cmd_load = 1'b0; cmd_read = 1'b0;
        check("ld_start_ready", wr_ready, 1);
        for (int i = 0; i < w.size(); i++) begin
            if (poke_read && i == 1) begin
                cmd_read = 1'b1;
                @(negedge clk);
                cmd_read = 1'b0;
            end
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                if (sr_clk !== 1'b0) viol++;
            end
            wr_valid = 1'b1; wr_data = w[i]; k = 0;
            while (!wr_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("ld_word_ready", wr_ready, 1);
            @(negedge clk);
            wr_valid = 1'b0;
        end
        if (complete) begin
            k = 0;
            while (busy && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("ld_busy_done", busy, 0);
            check("ld_sr_shifts", shift_cnt - sb, w.size());
            check("ld_plain_shifts", plain_shift_cnt - pb, w.size());
            check("ld_stall_sr_clk", viol, 0);
            check("ld_recirc_idle", sr_recirc, 1);
            check("ld_sr_d_hold", sr_d, w[w.size()-1]);
            if (gap == 0 && !poke_read) check("ld_busy_cycles", busy_cycles - bb, 2 * LENGTH);
            last_load_sum = xor_of(w);
        end
    endtask

    // stall < 0 picks a random 0..4 cycle rd_ready delay per word.
    task automatic run_read(input int stall);
        hex_word_t exp[$];
        hex_word_t got[$];
        int sb, pb, bb, wait_cnt, cur_stall, k, viol;
        logic exp_err;
        exp = sr_model; sb = shift_cnt; pb = plain_shift_cnt; bb = busy_cycles;
        cur_stall = (stall < 0) ? int'($urandom_range(0, 4)) : stall;
        wait_cnt = 0; k = 0; viol = 0;
        cmd_read = 1'b1;
        @(negedge clk);
        cmd_read = 1'b0;
        while (got.size() < LENGTH && k < 200) begin
            rd_ready = rd_valid && (wait_cnt >= cur_stall);
            if (rd_valid && !rd_ready && wait_cnt >= 1 && sr_clk !== 1'b0) viol++;
            if (rd_ready) begin
                got.push_back(rd_data);
                wait_cnt = 0;
                cur_stall = (stall < 0) ? int'($urandom_range(0, 4)) : stall;
            end else if (rd_valid) begin
                wait_cnt++;
            end
            @(negedge clk);
            k++;
        end
        rd_ready = 1'b0;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rd_busy_done", busy, 0);
        check("rd_word_count", got.size(), LENGTH);
        for (int i = 0; i < got.size(); i++) check($sformatf("rd_word%0d", i), got[i], exp[i]);
        check("rd_sr_shifts", shift_cnt - sb, LENGTH);
        check("rd_recirc_held", plain_shift_cnt - pb, 0);
        check("rd_stall_sr_clk", viol, 0);
        check("rd_valid_drained", rd_valid, 0);
        if (stall == 0) check("rd_busy_cycles", busy_cycles - bb, 2 * LENGTH);
        exp_err = CHK_EN && (xor_of(exp) != last_load_sum);
        check("rd_chk_err", chk_err, exp_err);
    endtask

    initial begin
        hex_word_t words[$];
        hex_word_t first_read[$];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sr_clk", sr_clk, 0);
        check("rst_sr_recirc", sr_recirc, 1);
        check("rst_sr_d", sr_d, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_chk_err", chk_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic load then read, first word out is first word in
        words = '{6'h01, 6'h02, 6'h03, 6'h04};
        run_load(words, 0, 1'b0, 1'b0, 1'b1);
        first_read = sr_model;
        check("t1_tail_is_first", first_read[0], 6'h01);
        run_read(0);

        // 2: back-to-back read passes return the same sequence
        run_read(0);
        run_read(0);
        check("t2_contents_kept", xor_of(sr_model), xor_of(words));

        // 3: write gaps and read back-pressure
        words = '{6'h15, 6'h2A, 6'h3C, 6'h07};
        run_load(words, 3, 1'b0, 1'b0, 1'b1);
        run_read(5);

        // 4: simultaneous commands (load wins) and a read pulse while busy
        words = '{6'h30, 6'h0C, 6'h03, 6'h21};
        run_load(words, 1, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("t4_no_read_busy", busy, 0);
        check("t4_no_read_valid", rd_valid, 0);
        run_read(0);

        // 5: reset in the middle of a load pass
        words = '{6'h11, 6'h22};
        run_load(words, 0, 1'b0, 1'b0, 1'b0);
        check("t5_sr_clk_high_pre", sr_clk, 1);
        rst_n = 1'b0;
        last_load_sum = '0;
        #1;
        check("t5_sr_clk", sr_clk, 0);
        check("t5_busy", busy, 0);
        check("t5_rd_valid", rd_valid, 0);
        check("t5_wr_ready", wr_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        words = '{6'h2B, 6'h0E, 6'h33, 6'h19};
        run_load(words, 0, 1'b0, 1'b0, 1'b1);
        run_read(2);

        // 6: checksum against a corrupted SR word, then a clean pass
        words = '{6'h3F, 6'h00, 6'h00, 6'h00};
        run_load(words, 0, 1'b0, 1'b0, 1'b1);
        corrupt_pulse = 1'b1;
        #1;
        corrupt_pulse = 1'b0;
        run_read(0);
        run_load(words, 0, 1'b0, 1'b0, 1'b1);
        run_read(0);

        // Randomised passes
        for (int r = 0; r < 4; r++) begin
            words.delete();
            for (int i = 0; i < LENGTH; i++) words.push_back(hex_word_t'($urandom_range(0, 63)));
            run_load(words, -1, 1'b0, 1'b0, 1'b1);
            run_read(-1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
